dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Two-port arbiter and access sequencer in front of the 8 KiB word-wide data memory (byte range 0x2000–0x3FFF, synchronous read, 1-cycle read latency, full-word write enable).
- Port 0 serves the core load/store unit; port 1 serves the debug/DMA master.
- Grants one request at a time using round-robin arbitration.
- Performs range and alignment checks.
- Extracts and sign-extends byte/halfword loads, and implements byte/halfword stores as read-modify-write.

Parameters:
BASE_ADDR, 32'h0000_2000, lowest legal byte address (inclusive)
END_ADDR, 32'h0000_3FFF, highest legal byte address (inclusive)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_pN_req  in  1  request from port N (N=0,1); held with fields stable until o_pN_gnt
i_pN_we  in  1  1=store, 0=load
i_pN_size  in  2  00 byte, 01 half, 10 word, 11 illegal
i_pN_unsigned  in  1  load zero-extends when 1, sign-extends when 0
i_pN_addr  in  32  byte address
i_pN_wdata  in  32  store data, right-justified
o_pN_gnt  out  1  one-cycle pulse: request fields sampled this cycle
o_pN_ack  out  1  one-cycle pulse: transaction complete
o_pN_rdata  out  32  load result, valid while o_pN_ack=1, 0 otherwise
o_pN_err  out  1  valid with o_pN_ack: range or alignment fault
o_mem_wren  out  1  memory write enable
o_mem_addr  out  32  word-aligned byte address {addr[31:2],2'b00}
o_mem_wdata  out  32  memory write data
i_mem_rdata  in  32  memory read data, valid one cycle after o_mem_addr

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is IDLE.
  - Round-robin pointer is "last=1", so port 0 wins the first tie.
- FSM states: IDLE, ERR, RD, CAP, WR, ACK.
- IDLE arbitration:
  - If exactly one request is asserted, grant it.
  - If both are asserted, grant the port not granted last.
  - Pulse o_pN_gnt and latch we/size/unsigned/addr/wdata/port. Update the pointer on grant.
- Fault check, done on the latched request:
  - Fault if addr < BASE_ADDR, addr > END_ADDR, size=11, half with addr[0]=1, or word with addr[1:0]!=0.
  - Fault -> ERR. No memory access of any kind.
- Next state from IDLE, grant in cycle 0:
  - Fault -> ERR.
  - Word store -> WR.
  - Load or sub-word store -> RD.
- ERR: the next cycle is ACK with err=1 and rdata=0. Ack appears in cycle 2.
- Word store:
  - WR in cycle 1 drives wren=1, addr, wdata=latched wdata.
  - ACK in cycle 2.
- RD (cycle 1): drive o_mem_addr with wren=0.
- CAP (cycle 2):
  - Capture i_mem_rdata.
  - Load: extract lane, then ACK in cycle 3.
  - Sub-word store: register merged word, then WR in cycle 3 and ACK in cycle 4.
- Lane rules (little-endian):
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Loads sign- or zero-extend the selected lane to 32 bits.
  - Sub-word store merge replaces only the addressed byte/half with wdata[7:0] or wdata[15:0]; other lanes keep the read value.
- ACK:
  - o_pN_ack=1 for exactly one cycle, only on the granted port.
  - rdata is driven on that port only, and only for successful loads.
  - Then return to IDLE. A new grant is possible the cycle after ACK, never during ACK.
- o_mem_wren:
  - High only in WR, exactly one cycle per store.
  - o_mem_addr/o_mem_wdata are 0 in IDLE/ERR/ACK.
- Request lines:
  - Requests arriving while busy wait. No request is lost while req stays high.
  - The requester may drop req after gnt.
  - If req drops before gnt, nothing happens.
- Reset mid-operation:
  - The operation is aborted immediately, asynchronously: wren=0, no ack issued.
  - A memory write already clocked stands; a pending RMW write is dropped.
- Boundaries:
  - 0x2000 and 0x3FFF are legal.
  - 0x1FFF and 0x4000 fault.
  - Word at 0x3FFC is legal.

Test Plan:
- Word store/load round trip:
  - p0 store word 0xDEADBEEF @0x2004 -> gnt c0, wren c1 (addr 0x2004), ack c2 err=0.
  - p0 load word @0x2004 -> ack c3, rdata 0xDEADBEEF.
- Byte RMW and extension:
  - Store byte 0x80 @0x2006 over 0xDEADBEEF -> read c1, wren c3 wdata 0xDE80BEEF, ack c4.
  - Load byte signed @0x2006 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Halfword:
  - Store half 0x1234 @0x2002 over 0 -> memory word 0x12340000.
  - Load half signed @0x2000 -> 0x00000000.
- Faults:
  - Word @0x2002, half @0x2001, any access @0x1FFF or @0x4000, size=11 -> ack c2 err=1, rdata 0, o_mem_wren never asserted.
- Arbitration:
  - Both ports request continuously from reset -> grants alternate p0, p1, p0.
  - p1 alone while p0 idle -> p1 granted immediately; each ack only on its own port.
- Reset mid-RMW: deassert i_rst_n in CAP of a byte store -> all outputs 0 at once, no wren, no ack, memory word unchanged.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin two-port arbiter and access sequencer for the word-wide data memory,
// with range/alignment faults, sub-word load extension and read-modify-write sub-word stores.
module dmem_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter logic [31:0] END_ADDR  = 32'h0000_3FFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_p0_req,
    input  logic        i_p0_we,
    input  logic [1:0]  i_p0_size,
    input  logic        i_p0_unsigned,
    input  logic [31:0] i_p0_addr,
    input  logic [31:0] i_p0_wdata,
    output logic        o_p0_gnt,
    output logic        o_p0_ack,
    output logic [31:0] o_p0_rdata,
    output logic        o_p0_err,
    input  logic        i_p1_req,
    input  logic        i_p1_we,
    input  logic [1:0]  i_p1_size,
    input  logic        i_p1_unsigned,
    input  logic [31:0] i_p1_addr,
    input  logic [31:0] i_p1_wdata,
    output logic        o_p1_gnt,
    output logic        o_p1_ack,
    output logic [31:0] o_p1_rdata,
    output logic        o_p1_err,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);
    localparam logic [2:0] IDLE = 3'd0, ERR = 3'd1, RD = 3'd2, CAP = 3'd3, WR = 3'd4, ACK = 3'd5;

    logic [2:0]  state;
    logic        last, port, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, data;
    logic        gnt0, gnt1, s_we, s_uns, acking, fault, rd_ok;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, lane, load_val, mask, ins, merged;

    function automatic logic is_fault(input logic [31:0] a, input logic [1:0] s);
        return a < BASE_ADDR || a > END_ADDR || s == 2'b11 || (s == 2'b01 && a[0]) ||
               (s == 2'b10 && a[1:0] != 2'b00);
    endfunction

    always_comb begin
        // Grants are gated by reset so every output is quiet while reset is held.
        gnt0        = i_rst_n && state == IDLE && i_p0_req && (!i_p1_req || last);
        gnt1        = i_rst_n && state == IDLE && i_p1_req && (!i_p0_req || !last);
        s_we        = gnt1 ? i_p1_we : i_p0_we;
        s_size      = gnt1 ? i_p1_size : i_p0_size;
        s_uns       = gnt1 ? i_p1_unsigned : i_p0_unsigned;
        s_addr      = gnt1 ? i_p1_addr : i_p0_addr;
        s_wdata     = gnt1 ? i_p1_wdata : i_p0_wdata;
        lane        = i_mem_rdata >> {addr[1:0], 3'b000};
        load_val    = size == 2'b00 ? {{24{!uns && lane[7]}}, lane[7:0]} :
                      size == 2'b01 ? {{16{!uns && lane[15]}}, lane[15:0]} : i_mem_rdata;
        mask        = size == 2'b00 ? 32'h0000_00FF << {addr[1:0], 3'b000} : 32'h0000_FFFF << {addr[1], 4'b0000};
        ins         = size == 2'b00 ? {4{data[7:0]}} : {2{data[15:0]}};
        merged      = (i_mem_rdata & ~mask) | (ins & mask);
        acking      = state == ACK;
        fault       = is_fault(addr, size);
        rd_ok       = acking && !we && !fault;
        o_p0_gnt    = gnt0;
        o_p1_gnt    = gnt1;
        o_p0_ack    = acking && !port;
        o_p1_ack    = acking && port;
        o_p0_err    = acking && fault && !port;
        o_p1_err    = acking && fault && port;
        o_p0_rdata  = rd_ok && !port ? data : 32'h0;
        o_p1_rdata  = rd_ok && port ? data : 32'h0;
        o_mem_wren  = state == WR;
        o_mem_addr  = (state == RD || state == CAP || state == WR) ? {addr[31:2], 2'b00} : 32'h0;
        o_mem_wdata = state == WR ? data : 32'h0;
    end

    // data holds the store word at grant, then the extracted load or merged RMW word after CAP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            port  <= 1'b0;
            we    <= 1'b0;
            uns   <= 1'b0;
            size  <= 2'b00;
            addr  <= 32'h0;
            data  <= 32'h0;
        end else begin
            case (state)
                IDLE: if (gnt0 || gnt1) begin
                    port  <= gnt1;
                    last  <= gnt1;
                    we    <= s_we;
                    size  <= s_size;
                    uns   <= s_uns;
                    addr  <= s_addr;
                    data  <= s_wdata;
                    state <= is_fault(s_addr, s_size) ? ERR : (s_we && s_size == 2'b10) ? WR : RD;
                end
                ERR: state <= ACK;
                RD:  state <= CAP;
                CAP: begin
                    data  <= we ? merged : load_val;
                    state <= we ? WR : ACK;
                end
                WR:  state <= ACK;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: random and directed traffic on both ports, checked every cycle against a
// transaction-level model of the arbiter, latencies and a byte-addressed memory image.
module tb_dmem_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        p0_req = 0, p0_we = 0, p0_uns = 0, p1_req = 0, p1_we = 0, p1_uns = 0;
    logic [1:0]  p0_size = 0, p1_size = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic        p0_gnt, p0_ack, p0_err, p1_gnt, p1_ack, p1_err, mem_wren;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] ram [2048] = '{default: 32'h0};
    logic [7:0]  mm [8192] = '{default: 8'h0};
    int          n_chk = 0, n_fail = 0, wren_cnt = 0;
    logic [31:0] last_wdata = 32'h0;
    int          gq[$];

    dmem_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_size(p0_size), .i_p0_unsigned(p0_uns),
        .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .o_p0_gnt(p0_gnt), .o_p0_ack(p0_ack),
        .o_p0_rdata(p0_rdata), .o_p0_err(p0_err),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_size(p1_size), .i_p1_unsigned(p1_uns),
        .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .o_p1_gnt(p1_gnt), .o_p1_ack(p1_ack),
        .o_p1_rdata(p1_rdata), .o_p1_err(p1_err),
        .o_mem_wren(mem_wren), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr[12:2]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[12:2]];
    end

    always @(negedge clk) begin
        if (mem_wren) begin
            wren_cnt++;
            last_wdata = mem_wdata;
        end
        if (p0_gnt) gq.push_back(0);
        if (p1_gnt) gq.push_back(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_fault(input logic [31:0] a, input logic [1:0] s);
        return a < 32'h2000 || a > 32'h3FFF || s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        logic [31:0] v;
        int nb;
        nb = 1 << s;
        v = 32'h0;
        for (int i = 0; i < nb; i++) v |= 32'(mm[int'(a[12:0]) + i]) << (8 * i);
        if (!u && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        logic [31:0] w;
        int off, nb, wb;
        off = int'(a[1:0]);
        nb = 1 << s;
        wb = int'({a[12:2], 2'b00});
        for (int i = 0; i < 4; i++) w[8*i+:8] = (i >= off && i < off + nb) ? d[8*(i-off)+:8] : mm[wb+i];
        return w;
    endfunction

    function automatic void m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        for (int j = 0; j < (1 << s); j++) mm[int'(a[12:0]) + j] = d[8*j+:8];
    endfunction

    bit          busy = 0, mlast = 1, t_port, t_we, t_uns, t_fault, e_ack, e_wren;
    int          k = 0, lat = 0;
    logic [1:0]  t_size;
    logic [31:0] t_addr, t_wdata, e_rd;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0;
            mlast = 1;
            chk("rst_gnt_ack_err", {p1_gnt, p0_gnt, p1_ack, p0_ack, p1_err, p0_err}, 0);
            chk("rst_rdata0", p0_rdata, 0);
            chk("rst_rdata1", p1_rdata, 0);
            chk("rst_wren", mem_wren, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
        end else begin
            if (busy) k++;
            else if (p0_req || p1_req) begin
                t_port  = (p0_req && p1_req) ? !mlast : p1_req;
                t_we    = t_port ? p1_we : p0_we;
                t_size  = t_port ? p1_size : p0_size;
                t_uns   = t_port ? p1_uns : p0_uns;
                t_addr  = t_port ? p1_addr : p0_addr;
                t_wdata = t_port ? p1_wdata : p0_wdata;
                t_fault = m_fault(t_addr, t_size);
                lat     = t_fault ? 2 : (t_we && t_size == 2'd2) ? 2 : t_we ? 4 : 3;
                k = 0;
                busy = 1;
                mlast = t_port;
            end
            e_ack  = busy && k == lat;
            e_wren = busy && !t_fault && t_we && k == (t_size == 2'd2 ? 1 : 3);
            e_rd   = (e_ack && !t_we && !t_fault) ? m_load(t_addr, t_size, t_uns) : 32'h0;
            chk("gnt0", p0_gnt, busy && k == 0 && !t_port);
            chk("gnt1", p1_gnt, busy && k == 0 && t_port);
            chk("ack0", p0_ack, e_ack && !t_port);
            chk("ack1", p1_ack, e_ack && t_port);
            chk("err0", p0_err, e_ack && !t_port && t_fault);
            chk("err1", p1_err, e_ack && t_port && t_fault);
            chk("rdata0", p0_rdata, t_port ? 32'h0 : e_rd);
            chk("rdata1", p1_rdata, t_port ? e_rd : 32'h0);
            chk("wren", mem_wren, e_wren);
            if (e_wren) begin
                chk("wr_addr", mem_addr, {t_addr[31:2], 2'b00});
                chk("wr_data", mem_wdata, m_merge(t_addr, t_size, t_wdata));
            end else if (busy && k == 1 && !t_fault && !(t_we && t_size == 2'd2)) begin
                chk("rd_addr", mem_addr, {t_addr[31:2], 2'b00});
            end else if (!busy || k == 0 || k == lat || t_fault) begin
                chk("quiet_addr", mem_addr, 0);
                chk("quiet_wdata", mem_wdata, 0);
            end
            if (e_ack) begin
                if (t_we && !t_fault) m_store(t_addr, t_size, t_wdata);
                busy = 0;
            end
        end
    end

    task automatic drive(input bit p, input logic r, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            p1_req = r; p1_we = w; p1_size = s; p1_uns = u; p1_addr = a; p1_wdata = d;
        end else begin
            p0_req = r; p0_we = w; p0_size = s; p0_uns = u; p0_addr = a; p0_wdata = d;
        end
    endtask

    task automatic do_txn(input bit p, input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int l);
        int n;
        rd = 32'h0;
        e = 1'b0;
        l = 0;
        @(posedge clk);
        #1 drive(p, 1, w, s, u, a, d);
        n = 0;
        @(negedge clk);
        while (!(p ? p1_gnt : p0_gnt) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("gnt_wait", n, 0);
            drive(p, 0, 0, 0, 0, 0, 0);
            return;
        end
        @(posedge clk);
        #1 drive(p, 0, 0, 0, 0, 0, 0);
        do begin
            @(negedge clk);
            l++;
        end while (!(p ? p1_ack : p0_ack) && l < 20);
        chk("ack_wait", p ? p1_ack : p0_ack, 1);
        rd = p ? p1_rdata : p0_rdata;
        e = p ? p1_err : p0_err;
    endtask

    task automatic dir(input string name, input bit p, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] x_rd, input logic x_err, input int x_lat);
        logic [31:0] rd;
        logic e;
        int l;
        do_txn(p, w, s, u, a, d, rd, e, l);
        chk({name, "_rdata"}, rd, x_rd);
        chk({name, "_err"}, e, x_err);
        chk({name, "_lat"}, l, x_lat);
    endtask

    function automatic logic [31:0] raddr(input logic [1:0] s);
        int r;
        logic [31:0] a;
        r = int'($urandom_range(0, 9));
        a = r == 0 ? 32'h1FFC + $urandom_range(0, 3) : r == 1 ? 32'h4000 + $urandom_range(0, 3) :
            r == 2 ? 32'h3FFC + $urandom_range(0, 3) : 32'h2000 + $urandom_range(0, 63);
        if ($urandom_range(0, 3) != 0) a = s == 2'd1 ? {a[31:1], 1'b0} : s == 2'd2 ? {a[31:2], 2'b00} : a;
        return a;
    endfunction

    task automatic rand_port(input bit p, input int n);
        logic [31:0] rd;
        logic e;
        int l;
        logic [1:0] s;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            s = 2'($urandom_range(0, 3));
            do_txn(p, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), raddr(s), $urandom, rd, e, l);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, n_chk=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] fa [5] = '{32'h2002, 32'h2001, 32'h1FFF, 32'h4000, 32'h2000};
    logic [1:0]  fs [5] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd3};

    initial begin
        logic [31:0] rd0, rd1;
        logic e0, e1;
        int l0, l1, w0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        fork
            begin
                do_txn(0, 1, 2'd2, 0, 32'h2010, 32'h1111_1111, rd0, e0, l0);
                do_txn(0, 1, 2'd2, 0, 32'h2014, 32'h3333_3333, rd0, e0, l0);
            end
            do_txn(1, 1, 2'd2, 0, 32'h2018, 32'h2222_2222, rd1, e1, l1);
        join
        chk("arb_count", gq.size(), 3);
        chk("arb_first", gq[0], 0);
        chk("arb_second", gq[1], 1);
        chk("arb_third", gq[2], 0);

        dir("st_word", 0, 1, 2'd2, 0, 32'h2004, 32'hDEAD_BEEF, 32'h0, 0, 2);
        dir("ld_word", 0, 0, 2'd2, 0, 32'h2004, 32'h0, 32'hDEAD_BEEF, 0, 3);
        dir("st_byte", 0, 1, 2'd0, 0, 32'h2006, 32'h0000_0080, 32'h0, 0, 4);
        chk("rmw_byte_wdata", last_wdata, 32'hDE80_BEEF);
        dir("ld_byte_s", 0, 0, 2'd0, 0, 32'h2006, 32'h0, 32'hFFFF_FF80, 0, 3);
        dir("ld_byte_u", 0, 0, 2'd0, 1, 32'h2006, 32'h0, 32'h0000_0080, 0, 3);
        dir("st_half", 0, 1, 2'd1, 0, 32'h2002, 32'h0000_1234, 32'h0, 0, 4);
        chk("rmw_half_wdata", last_wdata, 32'h1234_0000);
        dir("ld_word0", 0, 0, 2'd2, 0, 32'h2000, 32'h0, 32'h1234_0000, 0, 3);
        dir("ld_half_s", 0, 0, 2'd1, 0, 32'h2000, 32'h0, 32'h0, 0, 3);
        dir("p1_ld", 1, 0, 2'd2, 0, 32'h2004, 32'h0, 32'hDE80_BEEF, 0, 3);

        w0 = wren_cnt;
        for (int i = 0; i < 5; i++) dir("fault", i[0], i[0], fs[i], 0, fa[i], 32'hFFFF_FFFF, 32'h0, 1, 2);
        chk("fault_no_wren", wren_cnt - w0, 0);

        dir("st_2000", 0, 1, 2'd0, 0, 32'h2000, 32'h0000_005A, 32'h0, 0, 4);
        dir("ld_2000", 1, 0, 2'd0, 0, 32'h2000, 32'h0, 32'h0000_005A, 0, 3);
        dir("st_3ffc", 1, 1, 2'd2, 0, 32'h3FFC, 32'hCAFE_F00D, 32'h0, 0, 2);
        dir("st_3fff", 0, 1, 2'd0, 0, 32'h3FFF, 32'h0000_00A7, 32'h0, 0, 4);
        dir("ld_3fff", 0, 0, 2'd0, 1, 32'h3FFF, 32'h0, 32'h0000_00A7, 0, 3);
        dir("ld_3ffc", 1, 0, 2'd2, 0, 32'h3FFC, 32'h0, 32'hA7FE_F00D, 0, 3);

        fork
            rand_port(0, 80);
            rand_port(1, 80);
        join

        dir("st_2020", 0, 1, 2'd2, 0, 32'h2020, 32'hA5A5_A5A5, 32'h0, 0, 2);
        w0 = wren_cnt;
        @(posedge clk);
        #1 drive(0, 1, 1, 2'd0, 0, 32'h2021, 32'h0000_003C);
        @(negedge clk);
        chk("rmw_abort_gnt", p0_gnt, 1);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_wren", mem_wren, 0);
        chk("async_addr", mem_addr, 0);
        chk("async_acks", {p0_ack, p1_ack}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        chk("abort_no_wren", wren_cnt - w0, 0);
        chk("abort_ram_kept", ram[8], 32'hA5A5_A5A5);
        dir("ld_2020", 0, 0, 2'd2, 0, 32'h2020, 32'h0, 32'hA5A5_A5A5, 0, 3);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
